// File: rtl/regfile_if.sv
// Operand-read, issue, write-back and PC-control bundle between issue logic and the register file.
// rd_valid qualifies rd_data_a/b one cycle after an accepted read; hazard is a same-cycle stall request.
interface regfile_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              use_a;
    logic              use_b;
    logic              fwd_en_a;
    logic              fwd_en_b;
    logic [DATA_W-1:0] fwd_data_a;
    logic [DATA_W-1:0] fwd_data_b;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_dst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              pc_stall;
    logic              pc_load;
    logic [DATA_W-1:0] pc_target;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid;
    logic              hazard;
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output rd_en, rd_addr_a, rd_addr_b, use_a, use_b,
               fwd_en_a, fwd_en_b, fwd_data_a, fwd_data_b,
               issue_en, issue_dst, wr_en, wr_addr, wr_data,
               pc_stall, pc_load, pc_target, dbg_sel,
        input  rd_data_a, rd_data_b, rd_valid, hazard, pc, dbg_data
    );

    modport slave (
        input  rd_en, rd_addr_a, rd_addr_b, use_a, use_b,
               fwd_en_a, fwd_en_b, fwd_data_a, fwd_data_b,
               issue_en, issue_dst, wr_en, wr_addr, wr_data,
               pc_stall, pc_load, pc_target, dbg_sel,
        output rd_data_a, rd_data_b, rd_valid, hazard, pc, dbg_data
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with write-to-read bypass, per-register busy scoreboard and hazard detection.
// Index 0 is the program counter: reads return pc, writes to it are dropped.
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int PC_STEP  = 2,
    parameter int RESET_PC = 0
) (
    input logic      clk,
    input logic      reset,
    regfile_if.slave bus
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_next;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] rd_data_a_q;
    logic [DATA_W-1:0] rd_data_b_q;
    logic              rd_valid_q;
    logic              byp_a;
    logic              byp_b;
    logic              blk_a;
    logic              blk_b;
    logic              hazard_c;
    logic              capture;
    logic              wr_hit;

    assign wr_hit = bus.wr_en && (bus.wr_addr != '0);

    // Operand select: forward override, then same-cycle write bypass, then storage.
    always_comb begin
        byp_a = wr_hit && (bus.wr_addr == bus.rd_addr_a);
        byp_b = wr_hit && (bus.wr_addr == bus.rd_addr_b);

        if (bus.fwd_en_a)             op_a = bus.fwd_data_a;
        else if (byp_a)               op_a = bus.wr_data;
        else if (bus.rd_addr_a == '0) op_a = pc_q;
        else                          op_a = regs[bus.rd_addr_a];

        if (bus.fwd_en_b)             op_b = bus.fwd_data_b;
        else if (byp_b)               op_b = bus.wr_data;
        else if (bus.rd_addr_b == '0) op_b = pc_q;
        else                          op_b = regs[bus.rd_addr_b];

        blk_a    = bus.use_a && busy[bus.rd_addr_a] && !bus.fwd_en_a && !byp_a;
        blk_b    = bus.use_b && busy[bus.rd_addr_b] && !bus.fwd_en_b && !byp_b;
        hazard_c = !reset && bus.rd_en && (blk_a || blk_b);
        capture  = bus.rd_en && !hazard_c;
    end

    // A new producer issued in the same cycle as a write-back keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (wr_hit)
            busy_next[bus.wr_addr] = 1'b0;
        if (capture && bus.issue_en && (bus.issue_dst != '0))
            busy_next[bus.issue_dst] = 1'b1;
    end

    always_comb begin
        if (bus.pc_load)       pc_next = bus.pc_target & ~DATA_W'(1);
        else if (bus.pc_stall) pc_next = pc_q;
        else                   pc_next = pc_q + DATA_W'(PC_STEP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr_hit) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= '0;
            pc_q        <= DATA_W'(RESET_PC);
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            busy       <= busy_next;
            pc_q       <= pc_next;
            rd_valid_q <= capture;
            if (capture) begin
                rd_data_a_q <= op_a;
                rd_data_b_q <= op_b;
            end
        end
    end

    assign bus.rd_data_a = rd_data_a_q;
    assign bus.rd_data_b = rd_data_b_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.hazard    = hazard_c;
    assign bus.pc        = pc_q;
    assign bus.dbg_data  = (bus.dbg_sel == '0) ? pc_q : regs[bus.dbg_sel];
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the 16-bit pipelined core. It is the successor to the fixed eight-entry file and adds configurable width and depth, write-to-read bypass, a per-register busy scoreboard with hazard detection, and a dedicated program counter at index 0 with hold, increment and load modes. It sits in the decode/register-read stage. Issue logic drives the read and destination addresses; the write-back stage drives the write port.

## Interface
Parameters:
- DATA_W, 16: register and data width in bits.
- ADDR_W, 3: register address width; NREGS = 2**ADDR_W. Index 0 is the PC.
- PC_STEP, 2: PC increment per advancing cycle.
- RESET_PC, 0: PC value loaded on reset.

Ports (all DATA_W wide unless stated):
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- rd_en, input, 1: read request this cycle.
- rd_addr_a, rd_addr_b, input, ADDR_W: source addresses.
- use_a, use_b, input, 1: the source is actually consumed. Unused sources never cause a hazard.
- fwd_en_a, fwd_en_b, input, 1: external ALU forward override.
- fwd_data_a, fwd_data_b, input: forwarded values.
- issue_en, input, 1: the instruction has a register destination.
- issue_dst, input, ADDR_W: destination to mark busy.
- wr_en, input, 1: write-back valid.
- wr_addr, input, ADDR_W: write-back address.
- wr_data, input: write-back data.
- pc_stall, input, 1: hold the PC.
- pc_load, input, 1: redirect the PC.
- pc_target, input: redirect address.
- rd_data_a, rd_data_b, output: registered operands.
- rd_valid, output, 1: registered; operands captured last cycle.
- hazard, output, 1: combinational stall request.
- pc, output: current PC.
- dbg_sel, input, ADDR_W: debug register select.
- dbg_data, output: combinational contents of the register selected by dbg_sel.

## Operation
- Storage: registers 1..NREGS-1 are general purpose. Index 0 is the PC.
  - Writes with wr_addr=0 are ignored.
  - Reads of index 0 return the current pc.
- Reset: all registers, busy bits, rd_data_a/b and rd_valid clear to 0. pc is set to RESET_PC. hazard is forced to 0 while reset is asserted.
- Write: when wr_en=1 and wr_addr≠0, reg[wr_addr] takes wr_data at the edge, and busy[wr_addr] clears.
- Read source selection for port A (port B is identical), highest priority first:
  1. fwd_data_a when fwd_en_a=1.
  2. wr_data when wr_en=1, wr_addr=rd_addr_a and rd_addr_a≠0 (bypass).
  3. reg[rd_addr_a].
- Hazard: hazard = rd_en and (src_a_blocked or src_b_blocked).
  - src_x_blocked = use_x, and busy[rd_addr_x], and no forward on that port, and no bypass match on that port.
- When hazard=1:
  - rd_data_a/b hold their values and rd_valid goes to 0.
  - issue_en is ignored, so no busy bit is set.
- When rd_en=1 and hazard=0: the selected operands are captured and rd_valid goes to 1. If issue_en=1 and issue_dst≠0, busy[issue_dst] is set.
- When rd_en=0: rd_data_a/b hold and rd_valid goes to 0.
- Busy bit set and clear on the same register in the same cycle: set wins, because a new producer is in flight.
- Busy bit 0 is never set. issue_dst=0 has no effect.
- PC update, in priority order:
  1. pc_load: pc takes pc_target with bit 0 forced to 0.
  2. pc_stall: pc holds.
  3. Otherwise: pc takes pc + PC_STEP, modulo 2**DATA_W (wraps from 0xFFFE to 0x0000 for the defaults).
- pc_load takes effect even when hazard=1. pc_stall is driven by the pipeline from hazard; this block does not gate the PC on hazard.

## Timing
- Read latency is one cycle: addresses presented in cycle N give rd_data in cycle N+1, qualified by rd_valid.
- The bypass makes the result of a write in cycle N visible to a read in the same cycle N.
- hazard is combinational from current inputs and busy state, with no register stage.
- A busy bit set at edge N blocks reads from cycle N+1 onward.
- A clear at edge M unblocks reads from cycle M+1. The same-cycle bypass unblocks reads already in cycle M.
- Reset mid-operation: all state clears asynchronously, including pending busy bits. The first edge after reset deasserts performs a normal update.

## Test plan
- Reset, then 3 free-running cycles → pc sequence 0, 2, 4, 6. rd_valid=0 and all registers read 0.
- Write r3=0x1234, then read a=3, b=0 in the following cycle → next cycle rd_data_a=0x1234, rd_data_b equals the pc sampled in the read cycle, rd_valid=1.
- Same-cycle bypass: wr_en to r5=0xBEEF together with a read of r5 → rd_data_a=0xBEEF. Same cycle with fwd_en_a=1 and fwd_data_a=0x0042 → rd_data_a=0x0042 instead.
- Scoreboard:
  - Issue with dst=4, then read a=4 with use_a=1 → hazard=1, rd_valid=0, outputs held.
  - Write-back r4=0x0007 → hazard=0 in that cycle and rd_data_a=0x0007 next cycle.
  - Same scenario with use_a=0 → no hazard at any point.
- Simultaneous issue dst=2 and write-back r2 → busy[2] remains set and a subsequent read of r2 raises hazard.
- PC control:
  - pc_load=1 with pc_target=0x0101 → pc=0x0100.
  - pc_load and pc_stall asserted together → the load wins.
  - pc_stall for 2 cycles → pc holds.
  - pc at 0xFFFE, then advance → pc=0x0000.
  - reset asserted mid-stream → pc=0 and busy bits cleared immediately.
